// File: rtl/ber_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : ber_pkg
// Shared types and constants for the bit-error test path.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package ber_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ber_state_e;

  localparam int         c_ber_cnt_w    = 13;
  localparam int         c_prbs7_len    = 7;
  localparam logic [6:0] c_prbs7_seed   = 7'h7F;
  // x^7 + x^6 + 1 expressed as bit positions of a left-shifting register
  localparam int         c_prbs7_tap_hi = 6;
  localparam int         c_prbs7_tap_lo = 5;

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : prbs_lfsr
// Fibonacci LFSR with seed load and shift enable; MSB is the pattern bit.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module prbs_lfsr
  import ber_pkg::*;
#(
  parameter int             LEN    = c_prbs7_len,
  parameter logic [LEN-1:0] SEED   = c_prbs7_seed,
  parameter int             TAP_HI = c_prbs7_tap_hi,
  parameter int             TAP_LO = c_prbs7_tap_lo
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic shift_i,
  output logic msb_o
);

  logic [LEN-1:0] lfsr_q;
  logic [LEN-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (shift_i) begin
      lfsr_d = {lfsr_q[LEN-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign msb_o = lfsr_q[LEN-1];

endmodule
`default_nettype wire

// File: rtl/prbs_pattern_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : prbs_pattern_gen
// PRBS7 transmit source with error injection and a delayed clean reference.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module prbs_pattern_gen
  import ber_pkg::*;
#(
  parameter int LFSR_LEN = c_prbs7_len,
  parameter int CNT_W    = c_ber_cnt_w,
  parameter int DLY_W    = 4
) (
  input  logic             signal_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_bits,
  input  logic [DLY_W-1:0] delay_sel,
  input  logic             inject_err,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             ref_bit,
  output logic             ref_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bits_sent
);

  localparam int               c_dl_depth = (1 << DLY_W) - 1;
  localparam logic [DLY_W-1:0] c_dly_one  = DLY_W'(1);

  ber_state_e            state_q, state_d;
  logic [CNT_W-1:0]      num_q, num_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DLY_W-1:0]      dly_q, dly_d;
  logic [DLY_W-1:0]      flush_q, flush_d;
  logic [c_dl_depth-1:0] dl_bit_q, dl_bit_d;
  logic [c_dl_depth-1:0] dl_vld_q, dl_vld_d;

  logic                  w_emit;
  logic                  w_load;
  logic                  w_run_end;
  logic                  w_clean;
  logic                  w_entry_bit;
  logic [CNT_W:0]        w_cnt_inc;
  logic [c_dl_depth:0]   w_tap_bit;
  logic [c_dl_depth:0]   w_tap_vld;

  prbs_lfsr #(
    .LEN    (LFSR_LEN),
    .SEED   ({LFSR_LEN{1'b1}}),
    .TAP_HI (c_prbs7_tap_hi),
    .TAP_LO (c_prbs7_tap_lo)
  ) u_lfsr (
    .clk     (signal_clk),
    .rst     (rst),
    .load_i  (w_load),
    .shift_i (w_emit),
    .msb_o   (w_clean)
  );

  assign w_cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    w_emit    = 1'b0;
    w_load    = 1'b0;
    w_run_end = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && (num_bits != '0)) begin
          state_d = RUN;
          num_d   = num_bits;
          dly_d   = delay_sel;
          cnt_d   = '0;
          w_load  = 1'b1;
        end
      end
      RUN: begin
        // stop takes priority over the final bit: nothing is emitted this cycle
        if (stop) begin
          w_run_end = 1'b1;
        end else begin
          w_emit = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = w_cnt_inc[CNT_W-1:0];
          end
          if (w_cnt_inc >= {1'b0, num_q}) begin
            w_run_end = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_q == '0) begin
          state_d = DONE;
        end else begin
          flush_d = flush_q - c_dly_one;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_run_end) begin
      if (dly_q == '0) begin
        state_d = DONE;
      end else begin
        state_d = FLUSH;
        flush_d = dly_q - c_dly_one;
      end
    end

    w_entry_bit = w_emit & w_clean;
    if (w_load) begin
      dl_bit_d = '0;
      dl_vld_d = '0;
    end else begin
      dl_bit_d = {dl_bit_q[c_dl_depth-2:0], w_entry_bit};
      dl_vld_d = {dl_vld_q[c_dl_depth-2:0], w_emit};
    end
  end

  always_ff @(posedge signal_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      dly_q    <= '0;
      cnt_q    <= '0;
      flush_q  <= '0;
      dl_bit_q <= '0;
      dl_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      dl_bit_q <= dl_bit_d;
      dl_vld_q <= dl_vld_d;
    end
  end

  // Tap 0 is the live entry, giving zero-cycle pass-through for D = 0
  assign w_tap_bit = {dl_bit_q, w_entry_bit};
  assign w_tap_vld = {dl_vld_q, w_emit};

  assign tx_valid  = w_emit;
  assign tx_bit    = w_emit & (w_clean ^ inject_err);
  assign ref_bit   = w_tap_bit[dly_q];
  assign ref_valid = w_tap_vld[dly_q];
  assign busy      = (state_q == RUN) || (state_q == FLUSH);
  assign done      = (state_q == DONE);
  assign bits_sent = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_pattern_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_prbs_pattern_gen
// Directed self-checking bench for prbs_pattern_gen.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_prbs_pattern_gen;

  localparam int CNT_W = 13;
  localparam int DLY_W = 4;

  logic             signal_clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] num_bits;
  logic [DLY_W-1:0] delay_sel;
  logic             inject_err;
  logic             tx_bit;
  logic             tx_valid;
  logic             ref_bit;
  logic             ref_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bits_sent;

  int total;
  int bad;
  int right_cnt;
  int wrong_cnt;
  int rv_cnt;

  logic        clean_h [0:255];
  logic        tx_h    [0:255];
  logic [12:0] hand13;

  prbs_pattern_gen #(
    .LFSR_LEN (7),
    .CNT_W    (CNT_W),
    .DLY_W    (DLY_W)
  ) dut (
    .signal_clk (signal_clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .num_bits   (num_bits),
    .delay_sel  (delay_sel),
    .inject_err (inject_err),
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid),
    .ref_bit    (ref_bit),
    .ref_valid  (ref_valid),
    .busy       (busy),
    .done       (done),
    .bits_sent  (bits_sent)
  );

  initial signal_clk = 1'b0;
  always #5 signal_clk = ~signal_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge signal_clk);
    #1;
  endtask

  // Starts a run and checks every cycle through the done pulse and one idle cycle.
  task automatic run(input int n, input int d, input int stop_at, input int inj_at, input int busy_at);
    logic [6:0] m;
    int r, e;
    logic exp_v, exp_clean, exp_tx, exp_rv, exp_rb;
    m = 7'h7F;
    r = (stop_at != 0) ? stop_at : n;
    e = (stop_at != 0) ? stop_at - 1 : n;
    right_cnt = 0;
    wrong_cnt = 0;
    rv_cnt    = 0;
    num_bits  = CNT_W'(n);
    delay_sel = DLY_W'(d);
    start     = 1'b1;
    cyc();
    for (int i = 1; i <= r + d + 1; i++) begin
      stop       = (i == stop_at);
      inject_err = (i == inj_at);
      if (i == busy_at) begin
        start     = 1'b1;
        num_bits  = CNT_W'(3);
        delay_sel = DLY_W'(9);
      end else begin
        start = 1'b0;
      end
      #1;
      exp_v     = (i <= e);
      exp_clean = m[6];
      if (exp_v) clean_h[i] = exp_clean;
      exp_tx = exp_v ? (exp_clean ^ (i == inj_at)) : 1'b0;
      exp_rv = (i >= 1 + d) && (i <= e + d);
      exp_rb = exp_rv ? clean_h[i-d] : 1'b0;
      chk("tx_valid",  tx_valid,  exp_v);
      chk("tx_bit",    tx_bit,    exp_tx);
      chk("ref_valid", ref_valid, exp_rv);
      chk("ref_bit",   ref_bit,   exp_rb);
      chk("busy",      busy,      (i <= r + d));
      chk("done",      done,      (i == r + d + 1));
      chk("bits_sent", bits_sent, ((i - 1) < e) ? (i - 1) : e);
      if (i <= 13 && exp_v && i != inj_at) chk("hand13", tx_bit, hand13[13-i]);
      tx_h[i] = tx_bit;
      if (ref_valid === 1'b1) begin
        rv_cnt++;
        if (i > d && ref_bit === tx_h[i-d]) right_cnt++;
        else wrong_cnt++;
      end
      if (exp_v) m = {m[5:0], m[6] ^ m[5]};
      cyc();
    end
    start      = 1'b0;
    stop       = 1'b0;
    inject_err = 1'b0;
    #1;
    chk("post_done", done,     1'b0);
    chk("post_busy", busy,     1'b0);
    chk("post_txv",  tx_valid, 1'b0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    hand13     = 13'b1111111000000;
    rst        = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    num_bits   = '0;
    delay_sel  = '0;
    inject_err = 1'b0;

    // Reset values
    #1 rst = 1'b1;
    repeat (2) cyc();
    #1;
    chk("rst_tx_bit",    tx_bit,    1'b0);
    chk("rst_tx_valid",  tx_valid,  1'b0);
    chk("rst_ref_bit",   ref_bit,   1'b0);
    chk("rst_ref_valid", ref_valid, 1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_done",      done,      1'b0);
    chk("rst_bits_sent", bits_sent, 0);
    rst = 1'b0;
    cyc();

    // 20 bits, no delay
    run(20, 0, 0, 0, 0);

    // Full period with 5-cycle reference delay; LFSR returns to the seed
    run(127, 5, 0, 0, 0);
    chk("lfsr_wrap", {25'b0, dut.u_lfsr.lfsr_q}, 32'h7F);
    chk("ref_cnt_127", rv_cnt, 127);

    // Single injected error on bit 10 seen by a loopback comparator
    run(50, 0, 0, 10, 0);
    chk("loop_right", right_cnt, 49);
    chk("loop_wrong", wrong_cnt, 1);

    // Stop in RUN cycle 8 with D=3
    run(100, 3, 8, 0, 0);
    chk("stop_ref_cnt", rv_cnt, 7);
    chk("stop_bits",    bits_sent, 7);

    // start with num_bits = 0 is ignored
    num_bits = '0;
    start    = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk("zero_busy", busy,      1'b0);
    chk("zero_done", done,      1'b0);
    chk("zero_txv",  tx_valid,  1'b0);
    chk("zero_bits", bits_sent, 7);
    cyc();
    #1;
    chk("zero_done2", done, 1'b0);
    chk("zero_busy2", busy, 1'b0);

    // start while busy does not disturb the ongoing run
    run(10, 2, 0, 0, 4);

    // Asynchronous reset in RUN cycle 30
    num_bits  = CNT_W'(100);
    delay_sel = DLY_W'(4);
    start     = 1'b1;
    cyc();
    start = 1'b0;
    repeat (29) cyc();
    #1;
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_bit",    tx_bit,    1'b0);
    chk("mid_rst_tx_valid",  tx_valid,  1'b0);
    chk("mid_rst_ref_bit",   ref_bit,   1'b0);
    chk("mid_rst_ref_valid", ref_valid, 1'b0);
    chk("mid_rst_busy",      busy,      1'b0);
    chk("mid_rst_done",      done,      1'b0);
    chk("mid_rst_bits_sent", bits_sent, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_done", done, 1'b0);
    cyc();
    #1;
    chk("post_rst_done2", done, 1'b0);
    cyc();

    // Fresh start after reset restarts from the all-ones seed
    run(14, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs_pattern_gen.md
# prbs_pattern_gen

Transmit-side pattern source for the bit-error test path. On a start request it emits a fixed-length PRBS7 bit stream toward the channel under test, with optional single-bit error injection. It also provides a clean reference copy of the stream, delayed by a programmable number of cycles, so the receive-side error counter compares the received bit against a time-aligned reference. It runs in the same signal_clk domain as the error counter.

## Interface
- LFSR_LEN, 7: PRBS order; polynomial x^7 + x^6 + 1.
- CNT_W, 13: width of bit-count fields; matches the error counter's count width.
- DLY_W, 4: width of delay select; delay line depth is 2^DLY_W - 1 = 15.
- signal_clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset: asynchronous, active-high.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- stop  in  1  abort request; sampled only in RUN.
- num_bits  in  CNT_W  run length in bits; latched when start is accepted.
- delay_sel  in  DLY_W  reference delay in cycles (0..15); latched when start is accepted.
- inject_err  in  1  inverts tx_bit in the current RUN cycle.
- tx_bit  out  1  bit driven into the channel.
- tx_valid  out  1  tx_bit is a live pattern bit.
- ref_bit  out  1  clean pattern bit, delayed by the latched delay_sel.
- ref_valid  out  1  ref_bit is live; used as the error counter's count enable.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse at the end of a run.
- bits_sent  out  CNT_W  count of bits emitted in the current or last run.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: emits pattern bits.
  - FLUSH: drains the reference delay line.
  - DONE: one cycle; returns to IDLE.
- IDLE -> RUN when start=1 and num_bits != 0. On acceptance:
  - Latch num_bits and delay_sel.
  - Load the LFSR with all ones.
  - Clear bits_sent.
  - Clear the delay line.
- start with num_bits == 0 is ignored; the block stays in IDLE and done stays 0.
- start outside IDLE is ignored.
- RUN, each cycle:
  - tx_valid=1.
  - Clean bit = lfsr[6]; tx_bit = clean bit XOR inject_err.
  - LFSR shifts left, feedback lfsr[6]^lfsr[5] enters at bit 0.
  - bits_sent increments.
  - The clean bit and a valid flag enter the delay line. Injected errors never reach ref_bit.
- RUN -> FLUSH after the cycle in which bits_sent reaches the latched num_bits, or on the cycle stop=1.
  - The cycle in which stop is sampled emits no bit.
- FLUSH: tx_valid=0, tx_bit=0. The block stays in FLUSH for the latched delay of D cycles, then moves to DONE. With D=0 it goes to DONE directly.
- DONE: done=1 for one cycle, then IDLE. bits_sent holds its value until the next accepted start.
- Delay line:
  - ref_bit and ref_valid equal the clean bit and valid flag from D cycles earlier.
  - D=0 is combinational pass-through of the current RUN cycle.
  - Total ref_valid high cycles per run = bits_sent.
- bits_sent saturates at 2^CNT_W - 1; it never wraps.

## Timing
- Reset values:
  - State = IDLE, LFSR = all ones.
  - tx_bit=0, tx_valid=0, ref_bit=0, ref_valid=0.
  - busy=0, done=0, bits_sent=0, delay line cleared.
- start accepted at edge k -> first tx_valid at cycle k+1.
- For a full run of N bits with delay D:
  - tx_valid is high for cycles k+1 .. k+N.
  - ref_valid is high for cycles k+1+D .. k+N+D.
  - done is high at cycle k+N+D+1.
- rst asserted mid-run: all outputs return to reset values immediately. No done pulse is produced.
- stop and the last-bit condition in the same cycle: stop wins, that bit is not emitted, and bits_sent = N-1.
- PRBS period is 127. From the all-ones seed, bits 1–7 are 1 and bits 8–13 are 0.

## Structure
- Shared package ber_pkg holds:
  - State enum {IDLE, RUN, FLUSH, DONE}.
  - PRBS7 seed constant 7'h7F.
  - Tap positions.
  - Default CNT_W = 13, so the count width is shared with the error counter.
- One natural sub-module, prbs_lfsr: seed-load and shift enable in, MSB out. The checker side reuses it.
- The delay line is inline: a shift register with a mux selecting D.

## Test plan
- Reset, then start with num_bits=20, D=0: tx_bit is 1 for bits 1–7 and 0 for bits 8–13; tx_valid is high for 20 cycles; done pulses at cycle 21; bits_sent=20.
- num_bits=127, D=5: ref_bit equals tx_bit shifted by 5 cycles; after 127 bits the LFSR state is back to 7'h7F; done pulses at cycle 133.
- inject_err pulsed on bit 10 of a 50-bit run through a loopback into the error counter: tx_bit is inverted only on bit 10; the counter ends with right=49, wrong=1.
- stop asserted in RUN cycle 8 of a 100-bit run with D=3: bits_sent=7; ref_valid is high for exactly 7 cycles; done pulses 3 cycles after FLUSH entry.
- start with num_bits=0, and start asserted while busy: no state change and no done pulse; the ongoing run is undisturbed.
- rst pulsed at RUN cycle 30: all outputs return to reset values immediately; a fresh start restarts the sequence from the all-ones seed.
